sine_lookup_arbiter: RTL and testbench

- Shares one quarter-wave `sine_table` (8-bit index, 8-bit unsigned magnitude) between NUM_REQ requesters, e.g. oscillators and palette/scroll generators in the demo.
- Accepts full-circle phases, folds each phase into a quadrant and index, looks it up, and returns a signed 9-bit sample tagged with the requester ID.
- Round-robin arbitration, two-stage pipeline, throughput of one lookup per clock.

---
 rtl/sine_pkg.sv | 24 ++
 rtl/sine_rr_arbiter.sv | 28 ++
 rtl/sine_table.sv | 30 +++
 rtl/sine_lookup_arbiter.sv | 79 +++++++
 tb/tb_sine_lookup_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sine_pkg.sv
// sine_pkg: shared widths, quadrant type and phase folding for the sine lookup slice.
package sine_pkg;
   localparam int SINE_IN_BITS  = 8;
   localparam int SINE_OUT_BITS = 8;
   localparam int PHASE_BITS    = SINE_IN_BITS + 2;
   localparam int OUT_BITS      = SINE_OUT_BITS + 1;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

   typedef struct packed {
      logic                    sign;
      logic [SINE_IN_BITS-1:0] index;
   } fold_t;

   // Odd quadrants walk the quarter wave backwards; the lower half-circle is negative.
   function automatic fold_t fold(input logic [PHASE_BITS-1:0] phase);
      quadrant_t q;
      fold_t     f;
      q       = quadrant_t'(phase[PHASE_BITS-1 -: 2]);
      f.sign  = (q == Q2) || (q == Q3);
      f.index = (q == Q1) || (q == Q3) ? ~phase[SINE_IN_BITS-1:0] : phase[SINE_IN_BITS-1:0];
      return f;
   endfunction
endpackage

// File: rtl/sine_rr_arbiter.sv
// sine_rr_arbiter: combinational round-robin grant, searching upward from ptr+1.
module sine_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_BITS-1:0] ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_BITS-1:0] gid
);
   logic found;
   int   idx;

   always_comb begin
      grant = '0;
      gid   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            grant[idx] = 1'b1;
            gid        = ID_BITS'(idx);
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sine_table.sv
// sine_table: quarter-wave magnitude ROM, mag = min(255, round(256*sin(pi/2*index/256))).
module sine_table (
   input  logic [7:0] index,
   output logic [7:0] mag
);
   // Fixed-point Taylor series (Q28) so the ROM contents fold to constants at elaboration.
   function automatic logic [7:0] sine_val(input int i);
      longint x;
      longint term;
      longint acc;
      longint r;
      x    = (longint'(i) * 64'sd843314857) / 64'sd512;
      term = x;
      acc  = x;
      for (int k = 1; k < 12; k++) begin
         term = -((((term * x) >>> 28) * x) >>> 28) / longint'(2 * k * (2 * k + 1));
         acc  = acc + term;
      end
      r = (acc * 64'sd256 + 64'sd134217728) >>> 28;
      return r > 64'sd255 ? 8'd255 : 8'(r);
   endfunction

   logic [7:0] rom [256];

   for (genvar g = 0; g < 256; g++) begin : g_rom
      assign rom[g] = sine_val(g);
   end

   assign mag = rom[index];
endmodule

// File: rtl/sine_lookup_arbiter.sv
// sine_lookup_arbiter: shares one quarter-wave sine_table among NUM_REQ requesters,
// round-robin granted, two-stage pipeline returning a signed sample tagged with its ID.
module sine_lookup_arbiter
   import sine_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*PHASE_BITS-1:0] req_phase,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          resp_valid,
   output logic [ID_BITS-1:0]            resp_id,
   output logic [OUT_BITS-1:0]           resp_value
);
   logic [ID_BITS-1:0]      ptr;
   logic [NUM_REQ-1:0]      grant;
   logic [ID_BITS-1:0]      gid;
   logic                    xfer;
   logic [PHASE_BITS-1:0]   phase_sel;
   fold_t                   f;
   logic                    valid_a;
   logic [ID_BITS-1:0]      id_a;
   logic                    sign_a;
   logic [SINE_IN_BITS-1:0] index_a;
   logic [SINE_OUT_BITS-1:0] mag;

   sine_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) u_arb (
      .req_valid (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .gid       (gid)
   );

   sine_table u_table (
      .index (index_a),
      .mag   (mag)
   );

   assign req_ready = rst_n ? grant : '0;
   assign xfer      = |req_ready;
   assign phase_sel = req_phase[int'(gid)*PHASE_BITS +: PHASE_BITS];
   assign f         = fold(phase_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= ID_BITS'(NUM_REQ - 1);
         valid_a <= 1'b0;
         id_a    <= '0;
         sign_a  <= 1'b0;
         index_a <= '0;
      end else begin
         valid_a <= xfer;
         if (xfer) begin
            ptr     <= gid;
            id_a    <= gid;
            sign_a  <= f.sign;
            index_a <= f.index;
         end
      end
   end

   // Negating a zero magnitude yields zero, so no special case for phase 0x200.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_value <= '0;
      end else begin
         resp_valid <= valid_a;
         if (valid_a) begin
            resp_id    <= id_a;
            resp_value <= sign_a ? -{1'b0, mag} : {1'b0, mag};
         end
      end
   end
endmodule

// File: tb/tb_sine_lookup_arbiter.sv
// tb_sine_lookup_arbiter: random and directed stimulus scored against a real-valued sine model.
module tb_sine_lookup_arbiter;
   localparam int N  = 4;
   localparam int PB = 10;
   localparam int IB = 2;
   localparam int OB = 9;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*PB-1:0] req_phase = '0;
   logic [N-1:0]    req_ready;
   logic            resp_valid;
   logic [IB-1:0]   resp_id;
   logic [OB-1:0]   resp_value;

   always #5 clk = ~clk;

   sine_lookup_arbiter #(.NUM_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_phase  (req_phase),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_value (resp_value)
   );

   typedef struct {
      int id;
      int val;
      int due;
   } exp_t;

   exp_t         q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           mptr = N - 1;
   logic [N-1:0] last_grant = '0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_mag(input int i);
      real s;
      int  r;
      s = 256.0 * $sin(3.14159265358979 * i / 512.0);
      r = int'($floor(s + 0.5));
      return r > 255 ? 255 : r;
   endfunction

   function automatic int ref_val(input logic [PB-1:0] p);
      int qd;
      int lo;
      int m;
      qd = int'(p[PB-1:PB-2]);
      lo = int'(p[7:0]);
      m  = (qd % 2 == 1) ? ref_mag(255 - lo) : ref_mag(lo);
      return qd >= 2 ? -m : m;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : mon
      int eg;
      if (!rst_n) begin
         check("rst_valid", int'(resp_valid), 0);
         check("rst_id", int'(resp_id), 0);
         check("rst_value", int'(resp_value), 0);
         check("rst_ready", int'(req_ready), 0);
         q.delete();
         mptr = N - 1;
         last_grant = '0;
      end else begin
         if (q.size() != 0 && q[0].due == cyc) begin
            check("resp_valid", int'(resp_valid), 1);
            check("resp_id", int'(resp_id), q[0].id);
            check("resp_value", $signed(resp_value), q[0].val);
            void'(q.pop_front());
         end else begin
            check("resp_idle", int'(resp_valid), 0);
         end
         eg = -1;
         for (int k = 1; k <= N; k++)
            if (eg < 0 && req_valid[(mptr + k) % N]) eg = (mptr + k) % N;
         check("grant", int'(req_ready), eg < 0 ? 0 : (1 << eg));
         last_grant = eg < 0 ? '0 : N'(1 << eg);
         if (eg >= 0) begin
            mptr = eg;
            q.push_back('{eg, ref_val(req_phase[eg*PB +: PB]), cyc + 2});
         end
      end
   end

   task automatic lookup(input int id, input logic [PB-1:0] ph, input int exp_v);
      int n;
      @(posedge clk);
      #1;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_phase[id*PB +: PB] = ph;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[id] && n < 20);
      check("lookup_grant", int'(req_ready[id]), 1);
      @(posedge clk);
      #1 req_valid = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 5);
      check("lookup_latency", n, 2);
      check("lookup_id", int'(resp_id), id);
      check("lookup_value", $signed(resp_value), exp_v);
   endtask

   task automatic rand_run(input int n, input int pct);
      repeat (n) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++)
            if (!req_valid[i] || last_grant[i]) begin
               req_valid[i] = $urandom_range(99) < pct;
               req_phase[i*PB +: PB] = PB'($urandom);
            end
      end
   endtask

   initial begin
      int hold;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      lookup(0, 10'h040, 98);
      lookup(0, 10'h000, 0);
      lookup(0, 10'h0FF, 255);
      lookup(1, 10'h1C0, 97);
      lookup(2, 10'h240, -98);
      lookup(3, 10'h300, -255);
      lookup(1, 10'h3C0, -97);
      lookup(2, 10'h200, 0);
      lookup(3, 10'h2C0, ref_val(10'h2C0));
      rand_run(300, 50);
      rand_run(100, 90);
      @(posedge clk);
      #1 req_valid = '0;
      repeat (3) @(negedge clk);
      hold = $signed(resp_value);
      repeat (10) begin
         @(negedge clk);
         check("idle_ready", int'(req_ready), 0);
         check("idle_hold", $signed(resp_value), hold);
      end
      @(posedge clk);
      #1 req_valid = 4'b0100;
      @(negedge clk);
      check("rr_alone", int'(req_ready), 4'b0100);
      @(posedge clk);
      #1 req_valid = 4'b1010;
      @(negedge clk);
      check("rr_first", int'(req_ready), 4'b1000);
      @(posedge clk);
      #1 req_valid = 4'b0010;
      @(negedge clk);
      check("rr_second", int'(req_ready), 4'b0010);
      @(posedge clk);
      #1 req_valid = '1;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("flight_valid", int'(resp_valid), 0);
      check("flight_ready", int'(req_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_seq", int'(req_ready), 1 << (k % N));
         @(posedge clk);
         #1 req_phase[(k % N)*PB +: PB] = PB'($urandom);
      end
      rand_run(60, 100);
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(negedge clk);
      check("drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
